// File: rtl/pbit_comparator.sv
// P-bit comparator: signed tanh sample vs. Galois LFSR value, registered spin state.
// Define PBIT_FLIP_COUNT_EN to add the saturating flip_count output.
module pbit_comparator #(
    parameter int                TANH_W    = 8,
    parameter int                LFSR_W    = 32,
    parameter logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003,
    parameter logic [LFSR_W-1:0] SEED      = 32'hACE1_2468
`ifdef PBIT_FLIP_COUNT_EN
    ,
    parameter int                CNT_W     = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tanh_valid,
    input  logic [TANH_W-1:0] tanh,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed,
`ifdef PBIT_FLIP_COUNT_EN
    output logic [CNT_W-1:0]  flip_count,
`endif
    output logic              m_out,
    output logic              m_valid
);

    logic [LFSR_W-1:0] r_lfsr;
    logic [TANH_W-1:0] r_tanh_q;
    logic [TANH_W-1:0] r_rnd_q;
    logic              r_v1;

    logic [LFSR_W-1:0] w_lfsr_adv;
    logic [LFSR_W-1:0] w_lfsr_load;
    logic [TANH_W-1:0] w_rnd;
    logic              w_gt;

    assign w_lfsr_adv  = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_MASK : '0);
    // A zero seed would lock the LFSR, so fall back to the reset seed.
    assign w_lfsr_load = (seed == '0) ? SEED : seed;
    assign w_rnd       = r_lfsr[LFSR_W-1 -: TANH_W];
    assign w_gt        = $signed(r_tanh_q) > $signed(r_rnd_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (seed_load) begin
            r_lfsr <= w_lfsr_load;
        end else if (tanh_valid) begin
            r_lfsr <= w_lfsr_adv;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1     <= 1'b0;
            r_tanh_q <= '0;
            r_rnd_q  <= '0;
        end else begin
            r_v1 <= tanh_valid;
            if (tanh_valid) begin
                r_tanh_q <= tanh;
                r_rnd_q  <= w_rnd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out   <= 1'b0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= r_v1;
            if (r_v1) begin
                m_out <= w_gt;
            end
        end
    end

`ifdef PBIT_FLIP_COUNT_EN
    logic [CNT_W-1:0] r_flip_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flip_cnt <= '0;
        end else if (r_v1 && (w_gt != m_out) && (r_flip_cnt != '1)) begin
            r_flip_cnt <= r_flip_cnt + 1'b1;
        end
    end

    assign flip_count = r_flip_cnt;
`endif

endmodule
